cpu_jtag_ocimem_ctrl: RTL and testbench
=======================================

Name: cpu_jtag_ocimem_ctrl

Overview:
- System-clock-domain debug memory controller directly downstream of the CPU JTAG debug module's sysclk stage.
- Consumes the decoded JTAG command strobes (take_action_ocimem_a/b, take_no_action_ocimem_a) and the 38-bit jdo shift data.
- Executes single-word reads and writes on a pipelined memory-mapped master port.
- Returns MonDReg, monitor_ready and monitor_error back to the JTAG tck stage, which captures them for readback.

Parameters:
ADDR_W, 8, word-address width of MonAReg; the memory byte address is {MonAReg, 2'b00}
TIMEOUT, 255, bus cycles allowed per access before it is aborted with an error (1..2^16-1)

Ports:
clk  in  1  system clock, single clock domain
reset  in  1  synchronous, active-high reset
jdo  in  38  JTAG data from the sysclk stage
take_action_ocimem_a  in  1  1-cycle strobe: address/read command
take_action_ocimem_b  in  1  1-cycle strobe: write command
take_no_action_ocimem_a  in  1  1-cycle strobe: read at the current address with post-increment
m_address  out  ADDR_W+2  byte address
m_read  out  1  read request
m_write  out  1  write request
m_writedata  out  32  write data, equal to MonDReg
m_byteenable  out  4  constant 4'hF
m_waitrequest  in  1  slave stall
m_readdatavalid  in  1  read data valid
m_readdata  in  32  read data
MonAReg  out  ADDR_W  current word address
MonDReg  out  32  data register
monitor_ready  out  1  idle, last access complete
monitor_error  out  1  last access timed out or a command was dropped

Behaviour:
- Reset values (applied on the clock edge where reset=1, overriding everything else, including mid-access):
  - state IDLE; MonAReg=0; MonDReg=0; monitor_ready=1; monitor_error=0; m_read=0; m_write=0; timeout counter=0.
  - A bus access in flight is abandoned.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ. All outputs are registered.
- Commands are accepted only in IDLE. Priority when several strobes are high in the same cycle: b > a > no_action.
  - take_action_ocimem_a:
    - jdo[34]=1: MonAReg <= jdo[ADDR_W+1:2].
    - jdo[35]=1: start a read at the new address (or at the old address if jdo[34]=0).
    - jdo[35]=0: address load only; no bus access; monitor_ready stays 1.
  - take_no_action_ocimem_a: start a read at MonAReg.
  - take_action_ocimem_b: MonDReg <= jdo[34:3], then start a write at MonAReg.
- Accepting a command that starts an access clears monitor_ready and monitor_error, clears the timeout counter, and moves to RD_REQ or WR_REQ in the next cycle.
- A strobe that arrives while not in IDLE is dropped:
  - monitor_error <= 1 (sticky until the next accepted command); no other effect.
- RD_REQ:
  - m_read=1 and m_address={MonAReg,2'b00}, held stable.
  - In the first cycle with m_waitrequest=0, go to RD_WAIT and deassert m_read.
- RD_WAIT:
  - m_readdatavalid is sampled only in this state.
  - On m_readdatavalid=1: MonDReg <= m_readdata; MonAReg <= MonAReg+1; monitor_ready <= 1; go to IDLE.
- WR_REQ:
  - m_write=1 with m_writedata=MonDReg.
  - On m_waitrequest=0: MonAReg <= MonAReg+1; monitor_ready <= 1; go to IDLE.
- MonAReg increments modulo 2^ADDR_W; all-ones wraps to 0.
- Minimum latency, with the strobe in cycle T:
  - Read: m_read in T+1; if the slave answers with zero wait states, readdatavalid in T+2, and MonDReg and monitor_ready are visible in T+3.
  - Write: m_write in T+1; monitor_ready=1 in T+2.
- Timeout:
  - The counter increments every cycle the FSM is outside IDLE.
  - When counter==TIMEOUT in a cycle with no completion: go to IDLE; m_read/m_write deassert next cycle; monitor_error=1; monitor_ready=1; MonAReg and MonDReg unchanged.
  - If completion and timeout fall in the same cycle, completion wins and monitor_error stays 0.
- A read that completes while a new strobe is present in the same cycle: the strobe is dropped (FSM not yet IDLE) and monitor_error is set.

Test Plan:
- After reset: a strobe with jdo[35:34]=2'b11 and address field 0x10 -> m_read=1 with m_address=0x40; slave returns 0xCAFEF00D with zero wait -> MonDReg=0xCAFEF00D, MonAReg=0x11, monitor_ready=1 at T+3.
- take_action_ocimem_b with jdo[34:3]=0x12345678, MonAReg=0x11, m_waitrequest held high 3 cycles -> m_write held 4 cycles with m_writedata=0x12345678, m_address=0x44; then MonAReg=0x12 and ready=1.
- MonAReg=0xFF, take_no_action_ocimem_a -> read at m_address=0x3FC; after completion MonAReg=0x00.
- m_waitrequest stuck high, TIMEOUT=255 -> m_read drops after 256 cycles; monitor_error=1, monitor_ready=1, MonDReg unchanged; the next accepted command clears monitor_error.
- take_action_ocimem_b strobed during RD_WAIT -> write ignored, MonDReg still updated by the read data, monitor_error=1.
- Reset asserted during WR_REQ -> m_write=0 next cycle, MonAReg=0, MonDReg=0, ready=1, error=0.

Source files
------------

// File: rtl/cpu_jtag_ocimem_ctrl.sv
// Debug memory controller: turns decoded JTAG OCI-memory commands into single-word
// reads/writes on a pipelined memory-mapped master, with a per-access timeout.
module cpu_jtag_ocimem_ctrl #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [ADDR_W+1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [31:0]       m_writedata,
    output logic [3:0]        m_byteenable,
    input  logic              m_waitrequest,
    input  logic              m_readdatavalid,
    input  logic [31:0]       m_readdata,
    output logic [ADDR_W-1:0] MonAReg,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    localparam int unsigned CNT_W = 16;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_REQ  = 2'd1;
    localparam logic [1:0] RD_WAIT = 2'd2;
    localparam logic [1:0] WR_REQ  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] mon_a_q, mon_a_d;
    logic [31:0]       mon_d_q, mon_d_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic any_strobe;
    logic timed_out;
    logic unused_jdo;

    assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign timed_out  = (cnt_q == CNT_W'(TIMEOUT));
    assign unused_jdo = ^{jdo[37:36], jdo[1:0]};

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        mon_a_d = mon_a_q;
        mon_d_d = mon_d_q;
        ready_d = ready_q;
        error_d = error_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = (state_q != IDLE) ? cnt_q + CNT_W'(1) : cnt_q;

        case (state_q)
            IDLE: begin
                if (take_action_ocimem_b) begin
                    mon_d_d = jdo[34:3];
                    state_d = WR_REQ;
                    wr_d    = 1'b1;
                    ready_d = 1'b0;
                    error_d = 1'b0;
                    cnt_d   = '0;
                end else if (take_action_ocimem_a) begin
                    error_d = 1'b0;
                    if (jdo[34]) mon_a_d = jdo[ADDR_W+1:2];
                    if (jdo[35]) begin
                        state_d = RD_REQ;
                        rd_d    = 1'b1;
                        ready_d = 1'b0;
                        cnt_d   = '0;
                    end
                end else if (take_no_action_ocimem_a) begin
                    state_d = RD_REQ;
                    rd_d    = 1'b1;
                    ready_d = 1'b0;
                    error_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            RD_REQ: begin
                if (timed_out) begin
                    state_d = IDLE;
                    rd_d    = 1'b0;
                    ready_d = 1'b1;
                    error_d = 1'b1;
                end else if (!m_waitrequest) begin
                    state_d = RD_WAIT;
                    rd_d    = 1'b0;
                end
            end
            RD_WAIT: begin
                if (m_readdatavalid) begin
                    mon_d_d = m_readdata;
                    mon_a_d = mon_a_q + ADDR_W'(1);
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else if (timed_out) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    error_d = 1'b1;
                end
            end
            default: begin
                // Completion takes precedence over a coincident timeout
                if (!m_waitrequest) begin
                    mon_a_d = mon_a_q + ADDR_W'(1);
                    ready_d = 1'b1;
                    wr_d    = 1'b0;
                    state_d = IDLE;
                end else if (timed_out) begin
                    state_d = IDLE;
                    wr_d    = 1'b0;
                    ready_d = 1'b1;
                    error_d = 1'b1;
                end
            end
        endcase

        // Strobes outside IDLE are dropped and flagged
        if (state_q != IDLE && any_strobe) error_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mon_a_q <= '0;
            mon_d_q <= '0;
            ready_q <= 1'b1;
            error_q <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mon_a_q <= mon_a_d;
            mon_d_q <= mon_d_d;
            ready_q <= ready_d;
            error_q <= error_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign m_address     = {mon_a_q, 2'b00};
    assign m_read        = rd_q;
    assign m_write       = wr_q;
    assign m_writedata   = mon_d_q;
    assign m_byteenable  = 4'hF;
    assign MonAReg       = mon_a_q;
    assign MonDReg       = mon_d_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;

endmodule

// File: tb/tb_cpu_jtag_ocimem_ctrl.sv
// Directed bench for cpu_jtag_ocimem_ctrl: reads, writes, wrap, timeout, dropped
// strobes and reset during an access, with hand-computed expectations.
module tb_cpu_jtag_ocimem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic [9:0]  m_address;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [3:0]  m_byteenable;
    logic        m_waitrequest;
    logic        m_readdatavalid;
    logic [31:0] m_readdata;
    logic [7:0]  MonAReg;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cpu_jtag_ocimem_ctrl #(.ADDR_W(8), .TIMEOUT(255)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .m_address               (m_address),
        .m_read                  (m_read),
        .m_write                 (m_write),
        .m_writedata             (m_writedata),
        .m_byteenable            (m_byteenable),
        .m_waitrequest           (m_waitrequest),
        .m_readdatavalid         (m_readdatavalid),
        .m_readdata              (m_readdata),
        .MonAReg                 (MonAReg),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        reset = 1'b1;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        m_waitrequest = 1'b0;
        m_readdatavalid = 1'b0;
        m_readdata = '0;
        step();
        step();
        chk("rst_ready", 64'(monitor_ready), 64'd1);
        chk("rst_error", 64'(monitor_error), 64'd0);
        chk("rst_areg", 64'(MonAReg), 64'd0);
        chk("rst_dreg", 64'(MonDReg), 64'd0);
        chk("rst_rdwr", 64'({m_read, m_write}), 64'd0);
        chk("byteen", 64'(m_byteenable), 64'hF);
        reset = 1'b0;

        // Address load + read at 0x10, zero wait states
        jdo = '0; jdo[35] = 1'b1; jdo[34] = 1'b1; jdo[9:2] = 8'h10;
        take_action_ocimem_a = 1'b1;
        step();
        take_action_ocimem_a = 1'b0;
        chk("rd1_mread", 64'(m_read), 64'd1);
        chk("rd1_addr", 64'(m_address), 64'h40);
        chk("rd1_ready_low", 64'(monitor_ready), 64'd0);
        step();
        chk("rd1_mread_drop", 64'(m_read), 64'd0);
        m_readdatavalid = 1'b1; m_readdata = 32'hCAFEF00D;
        step();
        m_readdatavalid = 1'b0;
        chk("rd1_dreg", 64'(MonDReg), 64'hCAFEF00D);
        chk("rd1_areg", 64'(MonAReg), 64'h11);
        chk("rd1_ready", 64'(monitor_ready), 64'd1);
        chk("rd1_error", 64'(monitor_error), 64'd0);

        // Write with three wait states
        jdo = '0; jdo[34:3] = 32'h12345678;
        take_action_ocimem_b = 1'b1;
        m_waitrequest = 1'b1;
        step();
        take_action_ocimem_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("wr_mwrite", 64'(m_write), 64'd1);
            chk("wr_data", 64'(m_writedata), 64'h12345678);
            chk("wr_addr", 64'(m_address), 64'h44);
            if (i == 3) m_waitrequest = 1'b0;
            step();
        end
        chk("wr_mwrite_drop", 64'(m_write), 64'd0);
        chk("wr_areg", 64'(MonAReg), 64'h12);
        chk("wr_ready", 64'(monitor_ready), 64'd1);

        // Load 0xFF, then post-increment read wraps to 0
        jdo = '0; jdo[34] = 1'b1; jdo[9:2] = 8'hFF;
        take_action_ocimem_a = 1'b1;
        step();
        take_action_ocimem_a = 1'b0;
        chk("ld_areg", 64'(MonAReg), 64'hFF);
        chk("ld_noread", 64'(m_read), 64'd0);
        chk("ld_ready", 64'(monitor_ready), 64'd1);
        take_no_action_ocimem_a = 1'b1;
        step();
        take_no_action_ocimem_a = 1'b0;
        chk("wrap_mread", 64'(m_read), 64'd1);
        chk("wrap_addr", 64'(m_address), 64'h3FC);
        step();
        m_readdatavalid = 1'b1; m_readdata = 32'hA5A50001;
        step();
        m_readdatavalid = 1'b0;
        chk("wrap_areg", 64'(MonAReg), 64'h00);
        chk("wrap_dreg", 64'(MonDReg), 64'hA5A50001);

        // Timeout with waitrequest stuck high
        take_no_action_ocimem_a = 1'b1;
        m_waitrequest = 1'b1;
        step();
        take_no_action_ocimem_a = 1'b0;
        n = 0;
        while (m_read && n < 300) begin
            n++;
            step();
        end
        chk("to_cycles", 64'(n), 64'd256);
        chk("to_error", 64'(monitor_error), 64'd1);
        chk("to_ready", 64'(monitor_ready), 64'd1);
        chk("to_dreg", 64'(MonDReg), 64'hA5A50001);
        chk("to_areg", 64'(MonAReg), 64'h00);
        m_waitrequest = 1'b0;
        take_no_action_ocimem_a = 1'b1;
        step();
        take_no_action_ocimem_a = 1'b0;
        chk("to_clr_error", 64'(monitor_error), 64'd0);
        chk("to_clr_ready", 64'(monitor_ready), 64'd0);
        step();
        m_readdatavalid = 1'b1; m_readdata = 32'h11112222;
        step();
        m_readdatavalid = 1'b0;
        chk("to_next_dreg", 64'(MonDReg), 64'h11112222);
        chk("to_next_areg", 64'(MonAReg), 64'h01);

        // Write strobe during RD_WAIT is dropped
        take_no_action_ocimem_a = 1'b1;
        step();
        take_no_action_ocimem_a = 1'b0;
        step();
        jdo = '0; jdo[34:3] = 32'hDEADBEEF;
        take_action_ocimem_b = 1'b1;
        step();
        take_action_ocimem_b = 1'b0;
        chk("drop_error", 64'(monitor_error), 64'd1);
        chk("drop_nowrite", 64'(m_write), 64'd0);
        m_readdatavalid = 1'b1; m_readdata = 32'h55AA55AA;
        step();
        m_readdatavalid = 1'b0;
        chk("drop_dreg", 64'(MonDReg), 64'h55AA55AA);
        chk("drop_areg", 64'(MonAReg), 64'h02);
        chk("drop_ready", 64'(monitor_ready), 64'd1);
        chk("drop_error2", 64'(monitor_error), 64'd1);
        step();
        chk("drop_nowrite2", 64'(m_write), 64'd0);

        // Simultaneous a and b: write wins, no address load
        jdo = '0; jdo[35] = 1'b1; jdo[34:3] = 32'h80000001;
        take_action_ocimem_a = 1'b1;
        take_action_ocimem_b = 1'b1;
        step();
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        chk("prio_write", 64'({m_read, m_write}), 64'd1);
        chk("prio_dreg", 64'(MonDReg), 64'h80000001);
        chk("prio_addr", 64'(m_address), 64'h08);
        step();
        chk("prio_done_areg", 64'(MonAReg), 64'h03);
        chk("prio_done_ready", 64'(monitor_ready), 64'd1);

        // Reset during WR_REQ
        jdo = '0; jdo[34:3] = 32'h0BADC0DE;
        take_action_ocimem_b = 1'b1;
        m_waitrequest = 1'b1;
        step();
        take_action_ocimem_b = 1'b0;
        chk("rstwr_mwrite", 64'(m_write), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_waitrequest = 1'b0;
        chk("rstwr_mwrite0", 64'(m_write), 64'd0);
        chk("rstwr_areg", 64'(MonAReg), 64'd0);
        chk("rstwr_dreg", 64'(MonDReg), 64'd0);
        chk("rstwr_ready", 64'(monitor_ready), 64'd1);
        chk("rstwr_error", 64'(monitor_error), 64'd0);
        step();
        chk("rstwr_idle", 64'({m_read, m_write}), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
